// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive FIFO: capture FSM encoding,
// default FIFO depth and the UART baud divider constant.
package uart_rx_fifo_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_ACK  = 1'b1;

    typedef enum logic {
        IDLE = ST_IDLE,
        ACK  = ST_ACK
    } cap_state_e;

    localparam int FIFO_DEPTH = 16;

    // 115200 baud from a 100 MHz system clock
    localparam logic [15:0] UART_DIV = 16'd868;

endpackage : uart_rx_fifo_pkg

// File: rtl/byte_fifo_ram.sv
// DEPTH x 8 storage for the receive FIFO: one synchronous write port and
// one asynchronous read port, so the head byte falls straight through.
module byte_fifo_ram
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // NOTE: the array has no reset; stale contents are never visible because
    // the read side is qualified by occupancy, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : byte_fifo_ram

// File: rtl/uart_rx_fifo.sv
// Captures bytes from the UART receive buffer, acks each one with a single
// cycle pulse, and queues them in a first-word-fall-through FIFO.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ack,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [AW:0] count,
    output logic        overflow,
    input  logic        ovf_clr
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    cap_state_e  state_q, state_d;
    logic        ack_q, ack_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;

    logic       push, pop, space, wr_en, drop;
    logic [7:0] rd_data;

    // Pointers carry one extra bit so full and empty are distinguishable
    assign count   = wr_ptr_q - rd_ptr_q;
    assign m_valid = (count != '0);
    assign pop     = m_valid & m_ready;
    assign push    = (state_q == IDLE) & uart_rx_valid;
    assign space   = (count < FULL) | pop;
    assign wr_en   = push & space;
    assign drop    = push & ~space;

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (uart_rx_valid) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
        overflow_d = (overflow_q & ~ovf_clr) | drop;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    byte_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (uart_rx_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_data)
    );

    // Empty FIFO presents zero rather than whatever the array happens to hold
    assign m_data      = m_valid ? rd_data : 8'h00;
    assign uart_rx_ack = ack_q;
    assign overflow    = overflow_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic [7:0]    uart_rx_data;
    logic          uart_rx_valid;
    logic          uart_rx_ack;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready;
    logic [AW:0]   count;
    logic          overflow;
    logic          ovf_clr;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ack   (uart_rx_ack),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .count         (count),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: the FIFO is a queue, the uart handshake is "was the
    // previous cycle a capture", overflow is a sticky bit.
    logic [7:0] mq[$];
    bit         m_ack;
    bit         m_ovf;

    task automatic model_reset();
        mq.delete();
        m_ack = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input bit rv, input logic [7:0] d, input bit rdy, input bit clr);
        bit capture, popped, room;
        popped  = (mq.size() != 0) && rdy;
        capture = rv && !m_ack;
        room    = (mq.size() < DEPTH) || popped;
        if (clr) m_ovf = 1'b0;
        if (capture && !room) m_ovf = 1'b1;
        if (popped) void'(mq.pop_front());
        if (capture && room) mq.push_back(d);
        m_ack = capture;
    endtask

    // One clock: drive inputs, optionally compare against the model, advance
    task automatic cycle(input bit rv, input logic [7:0] d, input bit rdy, input bit clr,
                         input bit chk);
        uart_rx_valid = rv;
        uart_rx_data  = d;
        m_ready       = rdy;
        ovf_clr       = clr;
        #1;
        if (chk) begin
            check("ack", int'(uart_rx_ack), int'(m_ack));
            check("m_valid", int'(m_valid), int'(mq.size() != 0));
            check("count", int'(count), mq.size());
            check("overflow", int'(overflow), int'(m_ovf));
            if (mq.size() != 0) check("m_data", int'(m_data), int'(mq[0]));
        end
        @(posedge clk);
        model_step(rv, d, rdy, clr);
        #1;
    endtask

    typedef struct {
        bit         rv;
        logic [7:0] d;
        bit         rdy;
        bit         clr;
        bit         e_ack;
        bit         e_mv;
        logic [7:0] e_md;
        int         e_cnt;
        bit         e_ovf;
    } vec_t;

    vec_t vecs[10];
    logic [7:0] last_out;

    initial begin
        rstn = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'h00;
        m_ready = 1'b0;
        ovf_clr = 1'b0;
        model_reset();

        // Expected values are the outputs seen during the cycle, before its edge
        vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h41, 1, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41, 1, 1'b0};
        vecs[3] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0};
        vecs[4] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1, 1'b0};
        vecs[5] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 2, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 2, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", int'(uart_rx_ack), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_count", int'(count), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_m_data", int'(m_data), 8'h00);
        rstn = 1'b1;

        // Directed table: single byte, ack spacing, valid ignored during ack
        for (int i = 0; i < 10; i++) begin
            uart_rx_valid = vecs[i].rv;
            uart_rx_data  = vecs[i].d;
            m_ready       = vecs[i].rdy;
            ovf_clr       = vecs[i].clr;
            #1;
            check($sformatf("vec%0d_ack", i), int'(uart_rx_ack), int'(vecs[i].e_ack));
            check($sformatf("vec%0d_m_valid", i), int'(m_valid), int'(vecs[i].e_mv));
            check($sformatf("vec%0d_count", i), int'(count), vecs[i].e_cnt);
            check($sformatf("vec%0d_overflow", i), int'(overflow), int'(vecs[i].e_ovf));
            if (vecs[i].e_mv) check($sformatf("vec%0d_m_data", i), int'(m_data), int'(vecs[i].e_md));
            @(posedge clk);
            model_step(vecs[i].rv, vecs[i].d, vecs[i].rdy, vecs[i].clr);
            #1;
        end

        // Burst fill to full
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        check("full_count", int'(count), 16);
        check("full_overflow", int'(overflow), 0);
        check("full_head", int'(m_data), 8'h00);

        // Push into a full FIFO: dropped, still acked, overflow set
        cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        check("drop_ack", int'(uart_rx_ack), 1);
        check("drop_count", int'(count), 16);
        check("drop_overflow", int'(overflow), 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check("ovf_clr", int'(overflow), 0);

        // Clear and drop in the same cycle: set wins
        cycle(1'b1, 8'hBB, 1'b0, 1'b1, 1'b1);
        check("ovf_set_wins", int'(overflow), 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check("ovf_clr2", int'(overflow), 0);

        // Full with concurrent pop: push accepted
        cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
        check("fullpop_count", int'(count), 16);
        check("fullpop_overflow", int'(overflow), 0);
        last_out = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            if (m_valid) last_out = m_data;
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        end
        check("drain_last_byte", int'(last_out), 8'h55);
        check("drain_count", int'(count), 0);
        check("drain_m_valid", int'(m_valid), 0);

        // Wrap: 40 random bytes with m_ready toggling every cycle
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            cycle(1'b1, b, 1'b0, 1'b0, 1'b1);
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        end
        for (int i = 0; i < 50; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("wrap_count", int'(count), 0);

        // Reset during ACK with a byte left pending in the uart
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b1);
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        cycle(1'b1, 8'h05, 1'b0, 1'b0, 1'b1);
        check("pre_rst_ack", int'(uart_rx_ack), 1);
        check("pre_rst_count", int'(count), 5);
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h7E;
        rstn = 1'b0;
        #1;
        check("midrst_ack", int'(uart_rx_ack), 0);
        check("midrst_count", int'(count), 0);
        check("midrst_m_valid", int'(m_valid), 0);
        check("midrst_m_data", int'(m_data), 8'h00);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        cycle(1'b1, 8'h7E, 1'b0, 1'b0, 1'b1);
        check("post_rst_ack", int'(uart_rx_ack), 1);
        check("post_rst_m_valid", int'(m_valid), 1);
        check("post_rst_m_data", int'(m_data), 8'h7E);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("post_rst_count", int'(count), 1);

        // Randomized traffic: fill-biased, then drain-biased
        for (int i = 0; i < 600; i++) begin
            bit rv, rdy, clr;
            rv  = 1'($urandom_range(0, 1));
            rdy = (i < 300) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            clr = (($urandom % 16) == 0);
            cycle(rv, 8'($urandom), rdy, clr, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 SHALL have parameter AW, default 4, pointer width, equal to log2(DEPTH).
REQ-003 SHALL have port clk, input, 1, single system clock, rising edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port uart_rx_data, input, 8, received byte from the uart block (reg_dat_do).
REQ-006 SHALL have port uart_rx_valid, input, 1, uart receive buffer holds a byte (rx_valid).
REQ-007 SHALL have port uart_rx_ack, output, 1, one-cycle clear pulse to the uart (reg_dat_re).
REQ-008 SHALL have port m_data, output, 8, head-of-FIFO byte, first-word-fall-through.
REQ-009 SHALL have port m_valid, output, 1, FIFO not empty.
REQ-010 SHALL have port m_ready, input, 1, consumer accepts m_data this cycle.
REQ-011 SHALL have port count, output, AW+1, current occupancy 0..DEPTH.
REQ-012 SHALL have port overflow, output, 1, sticky flag: a byte was dropped.
REQ-013 SHALL have port ovf_clr, input, 1, synchronous clear of overflow.

Function
REQ-014 Capture FSM SHALL have states IDLE and ACK; encoding is held in the shared header.
REQ-015 IDLE with uart_rx_valid=1: the byte SHALL be pushed (if space), uart_rx_ack SHALL be registered high for the next cycle, and the FSM SHALL go to ACK.
REQ-016 ACK: uart_rx_ack SHALL be high for exactly this one cycle, uart_rx_valid SHALL be ignored, and the FSM SHALL return to IDLE unconditionally.
REQ-017 Each uart byte SHALL be pushed at most once; back-to-back bytes SHALL cost at least 2 cycles each.
REQ-018 Latency: a byte sampled in IDLE at cycle N SHALL appear as m_valid=1 with m_data equal to the byte in cycle N+1 when the FIFO was empty.
REQ-019 A pop SHALL occur when m_valid and m_ready are both 1; m_data SHALL advance on the following cycle.
REQ-020 Space SHALL exist when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-021 Push with no space: the byte SHALL be dropped, overflow SHALL be set to 1, the uart SHALL still be acked, and count SHALL be unchanged.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-023 Pop with m_valid=0 SHALL be ignored; count SHALL never underflow.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 count SHALL be (wr_ptr - rd_ptr) computed at AW+1 bits, modulo 2^(AW+1).
REQ-026 ovf_clr and a drop in the same cycle: overflow SHALL end at 1 (set wins).

Reset
REQ-027 rstn=0 SHALL asynchronously force: FSM=IDLE, uart_rx_ack=0, pointers=0, count=0, m_valid=0, overflow=0.
REQ-028 After reset, m_data SHALL be 8'h00; storage contents are don't-care.
REQ-029 Reset asserted mid-ACK SHALL abandon the ack; a byte still pending in the uart after reset SHALL be captured normally.
REQ-030 Reset release SHALL be synchronised at the top level; this block SHALL NOT contain its own synchroniser.

Structure
REQ-031 The shared header SHALL hold: FSM state localparams (IDLE=1'b0, ACK=1'b1), DEPTH default, and the uart divider constant 16'd868 (115200 baud at 100 MHz).
REQ-032 Storage SHALL be one sub-module, byte_fifo_ram: DEPTH x 8, one write port, asynchronous read, no reset on the array.
REQ-033 uart_rx_fifo SHALL contain no other sub-modules.

Verification
REQ-034 Single byte: uart_rx_valid=1 with 8'h41, m_ready=0 -> one-cycle ack; m_valid=1 and m_data=8'h41 next cycle; count=1.
REQ-035 Burst and ordering: push 8'h00..8'h0F with m_ready=0 -> count=16, overflow=0; then m_ready=1 -> 16 pops in order, m_valid=0, count=0.
REQ-036 Overflow: FIFO full, push 8'hAA -> byte dropped, ack pulsed, overflow=1, count=16; ovf_clr=1 -> overflow=0 next cycle.
REQ-037 Full with concurrent pop: count=16, push 8'h55 with m_ready=1 -> count stays 16, overflow=0, 8'h55 is the last byte out.
REQ-038 Wrap: 40 bytes streamed with m_ready toggling every cycle -> no loss, order kept, pointers wrap at least twice.
REQ-039 Reset mid-operation: count=5 and FSM in ACK, rstn=0 for 1 cycle -> count=0, m_valid=0, ack=0; a pending 8'h7E is captured after release.
